// File: rtl/requant_pack.sv
// Int32 accumulator requantizer: (acc+bias) << shift, SRDHM by multiplier, rounding right shift,
// offset and clamp, then pack int8 results into a return word.
module requant_pack #(
    parameter int INT32_SIZE = 32,
    parameter int PACK_SLOTS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [6:0]            cmd,
    input  logic [INT32_SIZE-1:0] inp0,
    input  logic [INT32_SIZE-1:0] inp1,
    output logic [INT32_SIZE-1:0] ret,
    output logic                  busy
);
    localparam int W  = INT32_SIZE;
    localparam int CW = $clog2(PACK_SLOTS + 1);
    localparam int PW = PACK_SLOTS * 8;
    localparam logic signed [2*W-1:0] HALF = (2*W)'(1) << (W-2);
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [2:0] {IDLE, ADD, MUL, RND, CLAMP} state_t;
    state_t state, state_nxt;

    logic signed [W-1:0] multiplier, shift, out_offset, act_min, act_max;
    logic signed [W-1:0] l_mult, l_shift, l_off, l_min, l_max, bias_r, dp;
    logic [PW-1:0]       pack, pack_nxt;
    logic [CW-1:0]       count, count_nxt;
    logic                overflow, pack_full, start_ok;

    assign busy      = (state != IDLE);
    assign pack_full = (count == CW'(PACK_SLOTS));
    assign start_ok  = (cmd == 7'd54) && (state == IDLE) && !pack_full;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = ADD;
            ADD:     state_nxt = MUL;
            MUL:     state_nxt = RND;
            RND:     state_nxt = CLAMP;
            CLAMP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One datapath register dp carries x, y, z through the stages.
    logic [W-1:0]          lsh, rs, mask, thr;
    logic signed [W-1:0]   x_add, y_mul, y_sh, z_rnd, w_clp;
    logic signed [2*W-1:0] prod, nudged, quo;
    logic signed [W:0]     wsum, min_ext, max_ext;
    logic                  rnd_up;

    always_comb begin
        lsh   = l_shift[W-1] ? '0 : l_shift;
        rs    = l_shift[W-1] ? -l_shift : '0;
        x_add = (dp + bias_r) << lsh;

        prod   = dp * l_mult;
        nudged = prod + (prod[2*W-1] ? ((2*W)'(1) - HALF) : HALF);
        quo    = nudged >>> (W-1);
        // Arithmetic shift floors; bump negatives with a remainder to truncate toward zero.
        if (nudged[2*W-1] && (|nudged[W-2:0])) quo = quo + (2*W)'(1);
        y_mul = quo[W-1:0];
        if (dp == SMIN && l_mult == SMIN) y_mul = SMAX;

        mask   = ~({W{1'b1}} << rs);
        thr    = (mask >> 1) + W'(dp[W-1]);
        y_sh   = dp >>> rs;
        rnd_up = (dp & mask) > thr;
        z_rnd  = y_sh + W'(rnd_up);

        wsum    = {dp[W-1], dp} + {l_off[W-1], l_off};
        min_ext = {l_min[W-1], l_min};
        max_ext = {l_max[W-1], l_max};
        if (wsum < min_ext)      w_clp = l_min;
        else if (wsum > max_ext) w_clp = l_max;
        else                     w_clp = wsum[W-1:0];
    end

    // A read (cmd 55) clears first, so a coincident CLAMP byte lands in lane 0.
    always_comb begin
        pack_nxt  = (cmd == 7'd55) ? '0 : pack;
        count_nxt = (cmd == 7'd55) ? '0 : count;
        if (state == CLAMP) begin
            for (int i = 0; i < PACK_SLOTS; i++)
                if (count_nxt == CW'(i)) pack_nxt[i*8 +: 8] = w_clp[7:0];
            count_nxt = count_nxt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            multiplier <= SMIN >> 1;
            shift      <= '0;
            out_offset <= '0;
            act_min    <= -W'(128);
            act_max    <= W'(127);
            l_mult     <= '0;
            l_shift    <= '0;
            l_off      <= '0;
            l_min      <= '0;
            l_max      <= '0;
            bias_r     <= '0;
            dp         <= '0;
            pack       <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            ret        <= '0;
        end else begin
            case (cmd)
                7'd50: multiplier <= inp1;
                7'd51: shift      <= inp1;
                7'd52: out_offset <= inp1;
                7'd53: begin act_min <= inp0; act_max <= inp1; end
                7'd55: ret <= W'(pack);
                7'd56: begin
                    ret      <= {{(W-3){1'b0}}, overflow, pack_full, busy};
                    overflow <= 1'b0;
                end
                default: ;
            endcase
            if (cmd == 7'd54 && pack_full) overflow <= 1'b1;
            if (start_ok) begin
                dp      <= inp0;
                bias_r  <= inp1;
                l_mult  <= multiplier;
                l_shift <= shift;
                l_off   <= out_offset;
                l_min   <= act_min;
                l_max   <= act_max;
            end
            case (state)
                ADD:     dp <= x_add;
                MUL:     dp <= y_mul;
                RND:     dp <= z_rnd;
                default: ;
            endcase
            pack  <= pack_nxt;
            count <= count_nxt;
        end
    end
endmodule

// File: tb/tb_requant_pack.sv
// Directed bench for requant_pack: vector table of single requantizations plus
// hand-written sequences for packing, overflow, read/write collision and reset abort.
module tb_requant_pack;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  cmd = '0;
    logic [31:0] inp0 = '0, inp1 = '0;
    logic [31:0] ret;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;

    requant_pack #(.INT32_SIZE(32), .PACK_SLOTS(4)) dut (
        .clk(clk), .reset_n(reset_n), .cmd(cmd), .inp0(inp0), .inp1(inp1),
        .ret(ret), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mult, shift, off, amin, amax, acc, bias;
        logic [7:0]  exp;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; return just after the next rising edge.
    task automatic cyc(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        cmd = c; inp0 = a; inp1 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        reset_n = 1'b1;
    endtask

    task automatic set_params(input logic [31:0] m, s, o, mn, mx);
        cyc(50, 0, m);
        cyc(51, 0, s);
        cyc(52, 0, o);
        cyc(53, mn, mx);
    endtask

    task automatic run_op(input logic [31:0] acc, input logic [31:0] bias);
        cyc(54, acc, bias);
        repeat (4) cyc(0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h40000000, 0, 0, -128, 127, 100, 0, 8'h32};
        vecs[1] = '{32'h40000000, 2, 0, -128, 127, 10, 5, 8'h1E};
        vecs[2] = '{32'h40000000, -1, 0, -128, 127, -6, 0, 8'hFE};
        vecs[3] = '{32'h7FFFFFFF, 0, -128, -128, 127, 1000, 0, 8'h7F};
        vecs[4] = '{32'h40000000, 0, 0, -128, 127, -1000, 0, 8'h80};
        vecs[5] = '{32'h40000000, 0, 5, -128, 127, 20, 0, 8'h0F};
        vecs[6] = '{32'h80000000, 0, 0, -128, 32'h7FFFFFFF, 32'h80000000, 0, 8'hFF};
        vecs[7] = '{32'h40000000, -2, 0, -128, 127, 6, 0, 8'h01};

        do_reset();
        check("reset_ret", ret, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            set_params(vecs[i].mult, vecs[i].shift, vecs[i].off, vecs[i].amin, vecs[i].amax);
            cyc(54, vecs[i].acc, vecs[i].bias);
            check($sformatf("v%0d_busy_start", i), {31'b0, busy}, 32'h1);
            repeat (3) cyc(0, 0, 0);
            check($sformatf("v%0d_busy_n3", i), {31'b0, busy}, 32'h1);
            cyc(0, 0, 0);
            check($sformatf("v%0d_busy_n4", i), {31'b0, busy}, 32'h0);
            cyc(55, 0, 0);
            check($sformatf("v%0d_byte", i), ret, {24'h0, vecs[i].exp});
        end

        // Fill the pack, then an extra start sets overflow and is dropped.
        do_reset();
        run_op(2, 0);
        run_op(4, 0);
        run_op(6, 0);
        run_op(8, 0);
        cyc(54, 10, 0);
        check("full_start_ignored", {31'b0, busy}, 32'h0);
        cyc(56, 0, 0);
        check("status_full_ovf", ret, 32'h6);
        cyc(55, 0, 0);
        check("pack4", ret, 32'h04030201);
        cyc(56, 0, 0);
        check("status_cleared", ret, 32'h0);

        // Start while busy is ignored.
        do_reset();
        cyc(54, 100, 0);
        cyc(54, 20, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check("busy_n3_ign", {31'b0, busy}, 32'h1);
        cyc(0, 0, 0);
        check("busy_n4_ign", {31'b0, busy}, 32'h0);
        cyc(55, 0, 0);
        check("busy_start_ignored", ret, 32'h00000032);

        // Read coinciding with the CLAMP write.
        do_reset();
        run_op(2, 0);
        cyc(54, 4, 0);
        repeat (3) cyc(0, 0, 0);
        cyc(55, 0, 0);
        check("collide_pre_write", ret, 32'h00000001);
        run_op(6, 0);
        cyc(55, 0, 0);
        check("collide_lane0_cnt1", ret, 32'h00000302);

        // Parameter write during busy applies to the next start only.
        do_reset();
        cyc(54, 100, 0);
        cyc(52, 0, 5);
        repeat (3) cyc(0, 0, 0);
        run_op(100, 0);
        cyc(55, 0, 0);
        check("param_latch", ret, 32'h00003732);

        // Reset during MUL aborts and restores default parameters.
        do_reset();
        set_params(32'h20000000, 1, 3, -5, 5);
        cyc(54, 100, 0);
        cyc(0, 0, 0);
        reset_n = 1'b0;
        cyc(0, 0, 0);
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_ret", ret, 32'h0);
        reset_n = 1'b1;
        repeat (4) cyc(0, 0, 0);
        cyc(55, 0, 0);
        check("abort_pack", ret, 32'h0);
        run_op(100, 0);
        cyc(55, 0, 0);
        check("abort_defaults", ret, 32'h00000032);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
